decodificador_trama_servos: RTL and testbench

DECODIFICADOR_TRAMA_SERVOS -- requirements
Module: decodificador_trama_servos

---
 rtl/servo_pkg.sv | 17 +
 rtl/temporizador_inactividad.sv | 36 +++
 rtl/decodificador_trama_servos.sv | 127 ++++++++++++
 tb/tb_decodificador_trama_servos.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Constants shared by the servo controller blocks: frame framing byte,
// frame length and decoder state encodings.
package servo_pkg;

  localparam logic [7:0] CABECERA   = 8'hFF;
  localparam int         LONG_TRAMA = 6;

  // Header + four angles + checksum; the data phase spans the middle bytes.
  localparam int         NUM_ANGULOS = LONG_TRAMA - 2;

  typedef logic [1:0] estado_t;

  localparam estado_t ESPERA_CABECERA = 2'd0;
  localparam estado_t DATOS           = 2'd1;
  localparam estado_t CHECKSUM        = 2'd2;

endpackage

// File: rtl/temporizador_inactividad.sv
// Inter-byte inactivity timer: counts idle cycles while enabled and flags
// expiry on the cycle whose closing edge would complete CICLOS idle cycles.
module temporizador_inactividad #(
  parameter int CICLOS = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic limpiar,
  input  logic habilitar,
  output logic expirado
);

  localparam int ANCHO = (CICLOS > 1) ? $clog2(CICLOS + 1) : 1;

  logic [ANCHO-1:0] cuenta_q, cuenta_d;

  assign expirado = habilitar && (cuenta_q == ANCHO'(CICLOS - 1));

  always_comb begin
    cuenta_d = cuenta_q;
    if (limpiar || !habilitar) begin
      cuenta_d = '0;
    end else if (!expirado) begin
      cuenta_d = cuenta_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

endmodule

// File: rtl/decodificador_trama_servos.sv
// Decodes 6-byte servo command frames (FF a1 a2 a3 a4 sum) from the UART
// byte stream and updates the four angle registers atomically on a good frame.
module decodificador_trama_servos
  import servo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 500000,
  parameter int ANGULO_MAX     = 180,
  parameter int ANGULO_INICIAL = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dato_rx,
  input  logic       dato_valido,
  output logic [7:0] angulo_servo_1,
  output logic [7:0] angulo_servo_2,
  output logic [7:0] angulo_servo_3,
  output logic [7:0] angulo_servo_4,
  output logic       trama_ok,
  output logic       error_trama,
  output logic       ocupado
);

  localparam logic [1:0] ULTIMO_INDICE = 2'(NUM_ANGULOS - 1);
  localparam logic [7:0] ANG_INI       = 8'(ANGULO_INICIAL);
  localparam logic [7:0] ANG_MAX       = 8'(ANGULO_MAX);

  estado_t               estado_q, estado_d;
  logic [1:0]            indice_q, indice_d;
  logic [7:0]            suma_q, suma_d;
  logic                  fuera_rango_q, fuera_rango_d;
  logic [3:0][7:0]       sombra_q, sombra_d;
  logic [3:0][7:0]       angulo_q, angulo_d;
  logic                  trama_ok_q, trama_ok_d;
  logic                  error_q, error_d;
  logic                  expirado;

  temporizador_inactividad #(
    .CICLOS (TIMEOUT_CICLOS)
  ) u_temporizador (
    .clk       (clk),
    .reset     (reset),
    .limpiar   (dato_valido),
    .habilitar (estado_q != ESPERA_CABECERA),
    .expirado  (expirado)
  );

  always_comb begin
    estado_d      = estado_q;
    indice_d      = indice_q;
    suma_d        = suma_q;
    fuera_rango_d = fuera_rango_q;
    sombra_d      = sombra_q;
    angulo_d      = angulo_q;
    trama_ok_d    = 1'b0;
    error_d       = 1'b0;
    // A byte in the same cycle as expiry wins: the timeout is only a fallback.
    if (dato_valido) begin
      case (estado_q)
        ESPERA_CABECERA: begin
          if (dato_rx == CABECERA) begin
            estado_d      = DATOS;
            indice_d      = 2'd0;
            suma_d        = 8'd0;
            fuera_rango_d = 1'b0;
          end
        end
        DATOS: begin
          if (dato_rx == CABECERA) begin
            indice_d      = 2'd0;
            suma_d        = 8'd0;
            fuera_rango_d = 1'b0;
          end else begin
            sombra_d[indice_q] = dato_rx;
            suma_d             = suma_q + dato_rx;
            if (dato_rx > ANG_MAX) fuera_rango_d = 1'b1;
            indice_d = indice_q + 2'd1;
            if (indice_q == ULTIMO_INDICE) estado_d = CHECKSUM;
          end
        end
        CHECKSUM: begin
          if ((dato_rx == suma_q) && !fuera_rango_q) begin
            angulo_d   = sombra_q;
            trama_ok_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          estado_d = ESPERA_CABECERA;
        end
        default: estado_d = ESPERA_CABECERA;
      endcase
    end else if (expirado) begin
      estado_d = ESPERA_CABECERA;
      error_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q      <= ESPERA_CABECERA;
      indice_q      <= 2'd0;
      suma_q        <= 8'd0;
      fuera_rango_q <= 1'b0;
      sombra_q      <= '0;
      angulo_q      <= {4{ANG_INI}};
      trama_ok_q    <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      indice_q      <= indice_d;
      suma_q        <= suma_d;
      fuera_rango_q <= fuera_rango_d;
      sombra_q      <= sombra_d;
      angulo_q      <= angulo_d;
      trama_ok_q    <= trama_ok_d;
      error_q       <= error_d;
    end
  end

  assign angulo_servo_1 = angulo_q[0];
  assign angulo_servo_2 = angulo_q[1];
  assign angulo_servo_3 = angulo_q[2];
  assign angulo_servo_4 = angulo_q[3];
  assign trama_ok       = trama_ok_q;
  assign error_trama    = error_q;
  assign ocupado        = (estado_q != ESPERA_CABECERA);

endmodule

// File: tb/tb_decodificador_trama_servos.sv
// Directed bench for the servo frame decoder with a short inactivity timeout.
module tb_decodificador_trama_servos;

  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dato_rx = 8'h00;
  logic       dato_valido = 1'b0;
  logic [7:0] a1, a2, a3, a4;
  logic       trama_ok, error_trama, ocupado;

  int checks = 0;
  int errores = 0;
  int n_ok = 0;
  int n_err = 0;
  int n_ambos = 0;
  int ok0, err0;

  decodificador_trama_servos #(
    .TIMEOUT_CICLOS (TIMEOUT),
    .ANGULO_MAX     (180),
    .ANGULO_INICIAL (90)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dato_rx        (dato_rx),
    .dato_valido    (dato_valido),
    .angulo_servo_1 (a1),
    .angulo_servo_2 (a2),
    .angulo_servo_3 (a3),
    .angulo_servo_4 (a4),
    .trama_ok       (trama_ok),
    .error_trama    (error_trama),
    .ocupado        (ocupado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (trama_ok) n_ok <= n_ok + 1;
    if (error_trama) n_err <= n_err + 1;
    if (trama_ok && error_trama) n_ambos <= n_ambos + 1;
  end

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: obtenido %0h, esperado %0h", tag, obs, esp);
    end
  endtask

  // Drives one byte for one cycle and returns on the negedge after it is sampled.
  task automatic enviar(input logic [7:0] b);
    @(negedge clk);
    dato_rx = b;
    dato_valido = 1'b1;
    @(negedge clk);
    dato_valido = 1'b0;
  endtask

  task automatic enviar_trama(input logic [47:0] t);
    for (int i = 5; i >= 0; i--) enviar(t[i*8 +: 8]);
  endtask

  function automatic logic [31:0] angulos();
    return {a4, a3, a2, a1};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: obtenido timeout, esperado fin");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chequear("reset_angulos", angulos(), 32'h5A5A5A5A);
    chequear("reset_ok", trama_ok, 0);
    chequear("reset_err", error_trama, 0);
    chequear("reset_ocupado", ocupado, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Bad checksum
    ok0 = n_ok; err0 = n_err;
    enviar_trama(48'hFF_0A_14_1E_28_65);
    chequear("cs_malo_err", error_trama, 1);
    chequear("cs_malo_ok", trama_ok, 0);
    chequear("cs_malo_angulos", angulos(), 32'h5A5A5A5A);
    @(negedge clk);
    chequear("cs_malo_pulsos_err", n_err - err0, 1);

    // Angle 181 with matching checksum
    err0 = n_err;
    enviar_trama(48'hFF_B5_00_00_00_B5);
    chequear("rango_err", error_trama, 1);
    chequear("rango_angulos", angulos(), 32'h5A5A5A5A);
    @(negedge clk);
    chequear("rango_pulsos_err", n_err - err0, 1);

    // Good frame
    ok0 = n_ok;
    enviar_trama(48'hFF_0A_14_1E_28_64);
    chequear("valida_ok", trama_ok, 1);
    chequear("valida_err", error_trama, 0);
    chequear("valida_angulos", angulos(), 32'h281E140A);
    chequear("valida_ocupado", ocupado, 0);
    @(negedge clk);
    chequear("valida_pulso_fin", trama_ok, 0);
    chequear("valida_pulsos_ok", n_ok - ok0, 1);

    // Angle exactly 180 and a checksum of 0xFF
    enviar_trama(48'hFF_B4_00_00_4B_FF);
    chequear("limite_ok", trama_ok, 1);
    chequear("limite_angulos", angulos(), 32'h4B0000B4);

    // Restart on a second header
    err0 = n_err;
    enviar(8'hFF); enviar(8'h0A); enviar(8'hFF);
    chequear("reinicio_ocupado", ocupado, 1);
    chequear("reinicio_err", error_trama, 0);
    enviar(8'h01); enviar(8'h02); enviar(8'h03); enviar(8'h04); enviar(8'h0A);
    chequear("reinicio_ok", trama_ok, 1);
    chequear("reinicio_angulos", angulos(), 32'h04030201);
    @(negedge clk);
    chequear("reinicio_pulsos_err", n_err - err0, 0);

    // Timeout after 100 silent cycles
    err0 = n_err;
    enviar(8'hFF); enviar(8'h0A);
    repeat (TIMEOUT - 1) @(negedge clk);
    chequear("timeout_antes_ocupado", ocupado, 1);
    chequear("timeout_antes_err", error_trama, 0);
    @(negedge clk);
    chequear("timeout_err", error_trama, 1);
    chequear("timeout_ocupado", ocupado, 0);
    chequear("timeout_angulos", angulos(), 32'h04030201);
    @(negedge clk);
    chequear("timeout_pulsos_err", n_err - err0, 1);

    // Byte arriving on the expiry cycle wins
    err0 = n_err;
    enviar(8'hFF); enviar(8'h0A);
    repeat (TIMEOUT - 2) @(negedge clk);
    enviar(8'h14);
    chequear("limite_t_ocupado", ocupado, 1);
    chequear("limite_t_err", error_trama, 0);
    enviar(8'h1E); enviar(8'h28); enviar(8'h64);
    chequear("limite_t_ok", trama_ok, 1);
    chequear("limite_t_angulos", angulos(), 32'h281E140A);
    @(negedge clk);
    chequear("limite_t_pulsos_err", n_err - err0, 0);

    // Reset mid-frame
    err0 = n_err; ok0 = n_ok;
    enviar(8'hFF); enviar(8'h0A); enviar(8'h14);
    reset = 1'b1;
    @(negedge clk);
    chequear("reset_medio_angulos", angulos(), 32'h5A5A5A5A);
    chequear("reset_medio_ocupado", ocupado, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chequear("reset_medio_pulsos_err", n_err - err0, 0);
    chequear("reset_medio_pulsos_ok", n_ok - ok0, 0);
    enviar_trama(48'hFF_05_06_07_08_1A);
    chequear("post_reset_ok", trama_ok, 1);
    chequear("post_reset_angulos", angulos(), 32'h08070605);
    @(negedge clk);

    chequear("total_ok", n_ok, 5);
    chequear("total_err", n_err, 3);
    chequear("nunca_ambos", n_ambos, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errores);
    $finish;
  end

endmodule
